// File: rtl/pipe_rr_sched_pkg.sv
// Shared definitions for pipe_rr_sched: default sizes, the tag-width helper,
// the tag-pipe stage record and the operand-slice packing macro.
package pipe_rr_sched_pkg;

  localparam int DW_DEF       = 10;
  localparam int NREQ_DEF     = 4;
  localparam int PIPE_LAT_DEF = 3;

  // Widest tag the tag pipe carries (NREQ is at most 8).
  localparam int TAG_MAX_W = 3;

  // Bits needed to encode n distinct values, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // One tag-pipe stage: an operation in flight and the requester that owns it.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_stage_t;

endpackage

// Part-select for requester i in a bus packed as NREQ slices of width w.
`define PRS_SLICE(i, w) ((i) * (w)) +: (w)

// File: rtl/pipe_rr_sched_if.sv
// Requester/datapath bundle for pipe_rr_sched. The scheduler uses the slave
// modport; the requester/datapath environment uses the master modport.
interface pipe_rr_sched_if
  import pipe_rr_sched_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*DW-1:0] req_c;
  logic [NREQ*DW-1:0] req_d;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      pipe_a;
  logic [DW-1:0]      pipe_b;
  logic [DW-1:0]      pipe_c;
  logic [DW-1:0]      pipe_d;
  logic               pipe_valid;
  logic [DW-1:0]      pipe_f;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_f;
  logic               busy;

  modport master (
    output req, req_a, req_b, req_c, req_d, pipe_f,
    input  gnt, pipe_a, pipe_b, pipe_c, pipe_d, pipe_valid, resp_valid, resp_f, busy
  );

  modport slave (
    input  req, req_a, req_b, req_c, req_d, pipe_f,
    output gnt, pipe_a, pipe_b, pipe_c, pipe_d, pipe_valid, resp_valid, resp_f, busy
  );

endinterface

// File: rtl/pipe_rr_sched_rr_arbiter.sv
// Combinational arbiter: one-hot grant plus encoded winner index.
// Round-robin from ptr_i by default; with PIPE_RR_SCHED_FIXED_PRIO_EN defined
// the lowest-index request wins and the ptr_i port does not exist.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TW   = 2
) (
`ifndef PIPE_RR_SCHED_FIXED_PRIO_EN
  input  logic [TW-1:0]   ptr_i,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [TW-1:0]   idx_o,
  output logic            any_o
);

  // Pick the first set request at or after the start index, wrapping at NREQ.
  always_comb begin
    int          start;
    int          j;
    logic [TW-1:0] jt;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jt    = '0;
`ifdef PIPE_RR_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = int'(ptr_i);
`endif
    for (int k = 0; k < NREQ; k++) begin
      j = start + k;
      if (j >= NREQ) j = j - NREQ;
      jt = TW'(j);
      if (!any_o && req_i[jt]) begin
        any_o = 1'b1;
        idx_o = jt;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/pipe_rr_sched.sv
// Shares one pipelined 4-operand datapath between NREQ requesters. Grants one
// request per cycle, registers its operands into the datapath, carries the
// requester tag down a shadow pipe matched to PIPE_LAT and returns each result
// to its owner. Define PIPE_RR_SCHED_FIXED_PRIO_EN for fixed-priority grants.
module pipe_rr_sched
  import pipe_rr_sched_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int TW       = clog2_min1(NREQ)
) (
  input logic           clk,
  input logic           rst_n,
  pipe_rr_sched_if.slave bus
);

  logic [NREQ-1:0] gnt;
  logic [TW-1:0]   win_idx;
  logic            win_any;

  logic [DW-1:0]   pipe_a_q, pipe_b_q, pipe_c_q, pipe_d_q;
  logic            pipe_valid_q;
  tag_stage_t      tag_q [PIPE_LAT+1];
  logic [NREQ-1:0] resp_valid_q;
  logic [DW-1:0]   resp_f_q;
  logic            busy_c;

`ifndef PIPE_RR_SCHED_FIXED_PRIO_EN
  logic [TW-1:0]   ptr_q, ptr_d;
`endif

  rr_arbiter #(.NREQ(NREQ), .TW(TW)) u_arb (
`ifndef PIPE_RR_SCHED_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .req_i (bus.req),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

`ifndef PIPE_RR_SCHED_FIXED_PRIO_EN
  // Move the pointer just past the winner, wrapping explicitly for non-power-of-2 NREQ.
  always_comb begin
    ptr_d = ptr_q;
    if (win_any) ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Launch the granted requester's operands into the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_a_q     <= '0;
      pipe_b_q     <= '0;
      pipe_c_q     <= '0;
      pipe_d_q     <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pipe_valid_q <= win_any;
      if (win_any) begin
        pipe_a_q <= bus.req_a[`PRS_SLICE(win_idx, DW)];
        pipe_b_q <= bus.req_b[`PRS_SLICE(win_idx, DW)];
        pipe_c_q <= bus.req_c[`PRS_SLICE(win_idx, DW)];
        pipe_d_q <= bus.req_d[`PRS_SLICE(win_idx, DW)];
      end
    end
  end

  // Shift the tag pipe every cycle; stage 0 records this cycle's winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset, unlike a data store, because clearing its valid bits is what drops in-flight operations.
      for (int s = 0; s <= PIPE_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: win_any, tag: TAG_MAX_W'(win_idx)};
      for (int s = 1; s <= PIPE_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Capture the datapath result for the owner named by the final tag stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_f_q     <= '0;
    end else if (tag_q[PIPE_LAT].valid) begin
      resp_valid_q <= NREQ'(1) << tag_q[PIPE_LAT].tag;
      resp_f_q     <= bus.pipe_f;
    end else begin
      resp_valid_q <= '0;
    end
  end

  // Busy while anything is launching, in the tag pipe, or being returned.
  always_comb begin
    busy_c = pipe_valid_q | (|resp_valid_q);
    for (int s = 0; s <= PIPE_LAT; s++) busy_c = busy_c | tag_q[s].valid;
  end

  assign bus.gnt        = gnt;
  assign bus.pipe_a     = pipe_a_q;
  assign bus.pipe_b     = pipe_b_q;
  assign bus.pipe_c     = pipe_c_q;
  assign bus.pipe_d     = pipe_d_q;
  assign bus.pipe_valid = pipe_valid_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_f     = resp_f_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Directed bench for pipe_rr_sched with a PIPE_LAT delay-line datapath stub
// computing F = A+B+C+D. Inputs change and outputs are sampled around the
// falling clock edge; the DUT registers on the rising edge.
module tb_pipe_rr_sched;

  localparam int DW       = 10;
  localparam int NREQ     = 4;
  localparam int PIPE_LAT = 3;

`ifdef PIPE_RR_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_rr_sched_if #(.DW(DW), .NREQ(NREQ)) bus ();

  pipe_rr_sched #(.DW(DW), .NREQ(NREQ), .PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath stub: not reset, so it keeps emitting results across a DUT reset.
  logic [DW-1:0] dl [PIPE_LAT];
  always @(posedge clk) begin
    dl[0] <= bus.pipe_a + bus.pipe_b + bus.pipe_c + bus.pipe_d;
    for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
  end
  assign bus.pipe_f = dl[PIPE_LAT-1];

  task automatic set_ops(input int i, input logic [DW-1:0] a, b, c, d);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_c[i*DW +: DW] = c;
    bus.req_d[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.req_d = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.pipe_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pipe_valid got=%b want=0", bus.pipe_valid); end
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0000", bus.resp_valid); end
    n_cmp++; if (bus.resp_f !== 10'd0) begin n_bad++; $display("FAIL reset_resp_f got=%0d want=0", bus.resp_f); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.pipe_a !== 10'd0) begin n_bad++; $display("FAIL reset_pipe_a got=%0d want=0", bus.pipe_a); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt_idle got=%b want=0000", bus.gnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // All four requesters held for 8 cycles; requester i sends 10*(i+1), i, 5, 1.
  task automatic test_all_req();
    int            sums [NREQ];
    int            w;
    logic [3:0]    exp_g, exp_rv;
    logic          exp_pv, exp_busy;
    sums = '{16, 27, 38, 49};
    for (int i = 0; i < NREQ; i++) set_ops(i, DW'(10 * (i + 1)), DW'(i), 10'd5, 10'd1);
    for (int c = 0; c < 15; c++) begin
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      w        = FIXED ? 0 : (c % 4);
      exp_g    = (c < 8) ? (4'b0001 << w) : 4'b0000;
      exp_pv   = (c >= 1 && c <= 8);
      exp_busy = (c >= 1 && c <= 12);
      n_cmp++; if (bus.gnt !== exp_g) begin n_bad++; $display("FAIL all_req_gnt c=%0d got=%b want=%b", c, bus.gnt, exp_g); end
      n_cmp++; if (bus.pipe_valid !== exp_pv) begin n_bad++; $display("FAIL all_req_pipe_valid c=%0d got=%b want=%b", c, bus.pipe_valid, exp_pv); end
      n_cmp++; if (bus.busy !== exp_busy) begin n_bad++; $display("FAIL all_req_busy c=%0d got=%b want=%b", c, bus.busy, exp_busy); end
      if (c >= 5 && c < 13) begin
        w      = FIXED ? 0 : ((c - 5) % 4);
        exp_rv = 4'b0001 << w;
        n_cmp++; if (bus.resp_valid !== exp_rv) begin n_bad++; $display("FAIL all_req_resp_valid c=%0d got=%b want=%b", c, bus.resp_valid, exp_rv); end
        n_cmp++; if (bus.resp_f !== DW'(sums[w])) begin n_bad++; $display("FAIL all_req_resp_f c=%0d got=%0d want=%0d", c, bus.resp_f, sums[w]); end
      end else begin
        n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL all_req_resp_idle c=%0d got=%b want=0000", c, bus.resp_valid); end
      end
      @(negedge clk);
    end
  endtask

  // Requester 0 alone: 10+12+6+3 = 31, result PIPE_LAT+2 cycles after the grant.
  task automatic test_single();
    logic [3:0] exp_rv;
    set_ops(0, 10'd10, 10'd12, 10'd6, 10'd3);
    bus.req = 4'b0001;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got=%b want=0001", bus.gnt); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      exp_rv = (c == 5) ? 4'b0001 : 4'b0000;
      n_cmp++; if (bus.pipe_valid !== (c == 1)) begin n_bad++; $display("FAIL single_pipe_valid c=%0d got=%b want=%b", c, bus.pipe_valid, (c == 1)); end
      n_cmp++; if (bus.resp_valid !== exp_rv) begin n_bad++; $display("FAIL single_resp_valid c=%0d got=%b want=%b", c, bus.resp_valid, exp_rv); end
      n_cmp++; if (bus.busy !== (c <= 5)) begin n_bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, bus.busy, (c <= 5)); end
      if (c == 1) begin
        n_cmp++; if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d} !== {10'd10, 10'd12, 10'd6, 10'd3}) begin
          n_bad++; $display("FAIL single_operands got=%0d,%0d,%0d,%0d want=10,12,6,3", bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d);
        end
      end
      if (c >= 5) begin
        n_cmp++; if (bus.resp_f !== 10'd31) begin n_bad++; $display("FAIL single_resp_f c=%0d got=%0d want=31", c, bus.resp_f); end
      end
    end
    @(negedge clk);
  endtask

  // Requester 3 (sum 26) then requester 1 (sum 28) on consecutive cycles.
  task automatic test_back_to_back();
    logic [3:0] g_exp  [8];
    logic [3:0] rv_exp [8];
    int         rf_exp [8];
    g_exp  = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rv_exp = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
    rf_exp = '{0, 0, 0, 0, 0, 26, 28, 0};
    set_ops(3, 10'd20, 10'd1, 10'd1, 10'd4);
    set_ops(1, 10'd10, 10'd10, 10'd5, 10'd3);
    for (int c = 0; c < 8; c++) begin
      bus.req = (c == 0) ? 4'b1000 : (c == 1) ? 4'b0010 : 4'b0000;
      #1;
      n_cmp++; if (bus.gnt !== g_exp[c]) begin n_bad++; $display("FAIL b2b_gnt c=%0d got=%b want=%b", c, bus.gnt, g_exp[c]); end
      n_cmp++; if (bus.resp_valid !== rv_exp[c]) begin n_bad++; $display("FAIL b2b_resp_valid c=%0d got=%b want=%b", c, bus.resp_valid, rv_exp[c]); end
      if (rv_exp[c] != 4'b0000) begin
        n_cmp++; if (bus.resp_f !== DW'(rf_exp[c])) begin n_bad++; $display("FAIL b2b_resp_f c=%0d got=%0d want=%0d", c, bus.resp_f, rf_exp[c]); end
      end
      if (c == 7) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end got=%b want=0", bus.busy); end
      end
      @(negedge clk);
    end
  endtask

  // Pointer sits at 2: req=0101 grants 2 then 0; an idle cycle keeps the pointer.
  task automatic test_ptr_skip();
    logic [3:0] req_v  [10];
    logic [3:0] g_exp  [10];
    logic [3:0] rv_exp [10];
    int         rf_exp [10];
    set_ops(0, 10'd1, 10'd1, 10'd1, 10'd1);
    set_ops(1, 10'd5, 10'd5, 10'd5, 10'd5);
    set_ops(2, 10'd2, 10'd2, 10'd2, 10'd2);
    set_ops(3, 10'd7, 10'd7, 10'd7, 10'd7);
    if (FIXED) begin
      req_v  = '{4'b0101, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      g_exp  = '{4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      rv_exp = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
      rf_exp = '{0, 0, 0, 0, 0, 4, 8, 0, 4, 0};
    end else begin
      req_v  = '{4'b0101, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      g_exp  = '{4'b0100, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      rv_exp = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
      rf_exp = '{0, 0, 0, 0, 0, 8, 4, 0, 20, 0};
    end
    for (int c = 0; c < 10; c++) begin
      bus.req = req_v[c];
      #1;
      n_cmp++; if (bus.gnt !== g_exp[c]) begin n_bad++; $display("FAIL ptr_gnt c=%0d got=%b want=%b", c, bus.gnt, g_exp[c]); end
      n_cmp++; if (bus.resp_valid !== rv_exp[c]) begin n_bad++; $display("FAIL ptr_resp_valid c=%0d got=%b want=%b", c, bus.resp_valid, rv_exp[c]); end
      if (rv_exp[c] != 4'b0000) begin
        n_cmp++; if (bus.resp_f !== DW'(rf_exp[c])) begin n_bad++; $display("FAIL ptr_resp_f c=%0d got=%0d want=%0d", c, bus.resp_f, rf_exp[c]); end
      end
      if (c == 3) begin
        n_cmp++; if (bus.pipe_valid !== 1'b0) begin n_bad++; $display("FAIL ptr_idle_pipe_valid got=%b want=0", bus.pipe_valid); end
      end
      @(negedge clk);
    end
  endtask

  // Three operations in flight, reset for one cycle: all dropped, nothing returned.
  task automatic test_reset_in_flight();
    for (int c = 0; c < 3; c++) begin
      bus.req = 4'b1111;
      @(negedge clk);
    end
    bus.req = 4'b0000;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rif_busy_before got=%b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.pipe_valid !== 1'b0) begin n_bad++; $display("FAIL rif_pipe_valid got=%b want=0", bus.pipe_valid); end
    n_cmp++; if (bus.pipe_a !== 10'd0) begin n_bad++; $display("FAIL rif_pipe_a got=%0d want=0", bus.pipe_a); end
    n_cmp++; if (bus.resp_f !== 10'd0) begin n_bad++; $display("FAIL rif_resp_f got=%0d want=0", bus.resp_f); end
    n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rif_resp_valid got=%b want=0000", bus.resp_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rif_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bus.resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rif_after_resp_valid c=%0d got=%b want=0000", c, bus.resp_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rif_after_busy c=%0d got=%b want=0", c, bus.busy); end
      n_cmp++; if (bus.resp_f !== 10'd0) begin n_bad++; $display("FAIL rif_after_resp_f c=%0d got=%0d want=0", c, bus.resp_f); end
    end
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_back_to_back();
    test_ptr_skip();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
